// File: rtl/rvfi_pc_window_check.sv
// rvfi_pc_window_check
//
// Checks PC continuity over a window of WINDOW consecutive rvfi_order values.
// For every slot k of the window it checks that pc_rdata(base+k) equals
// pc_wdata(base+k-1). Entries are matched by order number, so the retire
// channel and the retirement order do not matter. Results are reported on
// status outputs for a surrounding harness to assert on.
//
// Ports
//   clock         system clock
//   resetn        asynchronous active-low reset
//   arm           single-cycle start pulse, samples base_order
//   base_order    rvfi_order of the first checked instruction
//   rvfi_valid    per-channel retire valid
//   rvfi_order    per-channel order, channel i at [64*i +: 64]
//   rvfi_pc_rdata per-channel PC of the retiring instruction
//   rvfi_pc_wdata per-channel next PC
//   busy          checker is collecting
//   done          every slot of the window matched with no failure
//   fail          sticky failure flag
//   fail_code     bit0 = PC mismatch, bit1 = duplicate order
//   fail_slot     lowest slot index failing on the first failing edge
//   checked_cnt   number of slots checked so far

module rvfi_pc_window_check #(
  parameter int XLEN      = 32,
  parameter int NRET      = 1,
  parameter int WINDOW    = 4,
  parameter int ADDR_BITS = XLEN
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        arm,
  input  logic [63:0]                 base_order,
  input  logic [NRET-1:0]             rvfi_valid,
  input  logic [64*NRET-1:0]          rvfi_order,
  input  logic [XLEN*NRET-1:0]        rvfi_pc_rdata,
  input  logic [XLEN*NRET-1:0]        rvfi_pc_wdata,
  output logic                        busy,
  output logic                        done,
  output logic                        fail,
  output logic [1:0]                  fail_code,
  output logic [$clog2(WINDOW)-1:0]   fail_slot,
  output logic [$clog2(WINDOW+1)-1:0] checked_cnt
);

  localparam int SW = $clog2(WINDOW);
  localparam int CW = $clog2(WINDOW + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE, FAIL} stateT;

  stateT state_q, state_d;

  logic [63:0]                      base_q;
  logic [WINDOW-1:0][ADDR_BITS-1:0] actPc_q, actPc_d;
  logic [WINDOW-1:0][ADDR_BITS-1:0] expPc_q, expPc_d;
  logic [WINDOW-1:0]                actValid_q, expValid_q, checked_q;
  logic                             slot0Free_q;
  logic [CW-1:0]                    checkedCnt_q, checkedCnt_d;
  logic [1:0]                       failCode_q;
  logic [SW-1:0]                    failSlot_q;

  logic              collectEn;
  logic [WINDOW-1:0] actHit, expHit, dupMask;
  logic [WINDOW-1:0] completeMask, mismatchMask, failMask;
  logic [63:0]       actOff, expOff;
  logic [SW-1:0]     failIdx;
  logic              anyFail;

  // Captures and checks only run while collecting; an arm pulse overrides them.
  assign collectEn = (state_q == COLLECT) && !arm;

  // Map each retirement onto the window. Offsets use 64-bit wrap-around so
  // windows straddling order 2^64-1 work. One retirement may fill act[d] and
  // exp[d+1] together. A hit on an already-valid entry, or two channels
  // hitting the same entry on one edge, is a duplicate.
  always_comb begin
    actHit  = '0;
    expHit  = '0;
    dupMask = '0;
    actPc_d = actPc_q;
    expPc_d = expPc_q;
    actOff  = '0;
    expOff  = '0;
    for (int ch = 0; ch < NRET; ch++) begin
      actOff = rvfi_order[64*ch +: 64] - base_q;
      expOff = actOff + 64'd1;
      for (int k = 0; k < WINDOW; k++) begin
        if (collectEn && rvfi_valid[ch] && (actOff == 64'(k))) begin
          if (actValid_q[k] || actHit[k]) dupMask[k] = 1'b1;
          actHit[k]  = 1'b1;
          actPc_d[k] = rvfi_pc_rdata[XLEN*ch +: ADDR_BITS];
        end
        if (collectEn && rvfi_valid[ch] && (expOff == 64'(k))) begin
          if (expValid_q[k] || expHit[k]) dupMask[k] = 1'b1;
          expHit[k]  = 1'b1;
          expPc_d[k] = rvfi_pc_wdata[XLEN*ch +: ADDR_BITS];
        end
      end
    end
  end

  // A slot whose entries are both valid is compared one edge after its last
  // entry was captured. With base 0, slot 0 has no predecessor and always matches.
  always_comb begin
    completeMask = '0;
    mismatchMask = '0;
    checkedCnt_d = checkedCnt_q;
    for (int k = 0; k < WINDOW; k++) begin
      if (collectEn && actValid_q[k] && expValid_q[k] && !checked_q[k]) begin
        if (((k == 0) && slot0Free_q) || (actPc_q[k] == expPc_q[k])) begin
          completeMask[k] = 1'b1;
        end else begin
          mismatchMask[k] = 1'b1;
        end
      end
      checkedCnt_d = checkedCnt_d + CW'(completeMask[k]);
    end
  end

  // Lowest failing slot on this edge, whether mismatch or duplicate.
  always_comb begin
    failMask = dupMask | mismatchMask;
    anyFail  = |failMask;
    failIdx  = '0;
    for (int k = WINDOW - 1; k >= 0; k--) begin
      if (failMask[k]) failIdx = SW'(k);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // A failure on the same edge the count completes takes priority over done.
  always_comb begin
    state_d = state_q;
    if (arm) begin
      state_d = COLLECT;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (anyFail)                           state_d = FAIL;
          else if (checkedCnt_d == CW'(WINDOW))  state_d = DONE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Window storage, counters and failure record. Failure fields are written
  // only on the edge that enters FAIL, so they freeze afterwards.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      base_q       <= '0;
      actPc_q      <= '0;
      expPc_q      <= '0;
      actValid_q   <= '0;
      expValid_q   <= '0;
      checked_q    <= '0;
      slot0Free_q  <= 1'b0;
      checkedCnt_q <= '0;
      failCode_q   <= '0;
      failSlot_q   <= '0;
    end else if (arm) begin
      base_q       <= base_order;
      actValid_q   <= '0;
      expValid_q   <= {{(WINDOW-1){1'b0}}, (base_order == 64'd0)};
      checked_q    <= '0;
      slot0Free_q  <= (base_order == 64'd0);
      checkedCnt_q <= '0;
      failCode_q   <= '0;
      failSlot_q   <= '0;
    end else if (collectEn) begin
      actPc_q      <= actPc_d;
      expPc_q      <= expPc_d;
      actValid_q   <= actValid_q | actHit;
      expValid_q   <= expValid_q | expHit;
      checked_q    <= checked_q | completeMask;
      checkedCnt_q <= checkedCnt_d;
      if (anyFail) begin
        failCode_q <= {|dupMask, |mismatchMask};
        failSlot_q <= failIdx;
      end
    end
  end

  always_comb begin
    busy        = (state_q == COLLECT);
    done        = (state_q == DONE);
    fail        = (state_q == FAIL);
    fail_code   = failCode_q;
    fail_slot   = failSlot_q;
    checked_cnt = checkedCnt_q;
  end

endmodule

// File: tb/tb_rvfi_pc_window_check.sv
// tb_rvfi_pc_window_check
//
// Bench for rvfi_pc_window_check with two retire channels, a four-slot window
// and 16 compared PC bits. Each scenario is a list of retirement events; a
// reference model predicts the window outcome (done or fail, code, slot and
// the edge it appears on) and queues it. A monitor pops and compares whenever
// done or fail rises.

module tb_rvfi_pc_window_check;

  localparam int XLEN      = 32;
  localparam int NRET      = 2;
  localparam int WINDOW    = 4;
  localparam int ADDR_BITS = 16;
  localparam int INF       = 1000000;
  localparam longint unsigned PCMOD = 64'd1 << ADDR_BITS;

  typedef struct {
    int              cyc;
    int              ch;
    longint unsigned order;
    logic [31:0]     rd;
    logic [31:0]     wd;
  } ev_t;

  typedef struct {
    bit          isDone;
    logic [1:0]  code;
    int          slot;
    int          edgeRel;
    int          edgeAbs;
    string       name;
  } expect_t;

  logic                        clock = 1'b0;
  logic                        resetn = 1'b1;
  logic                        arm = 1'b0;
  logic [63:0]                 base_order = '0;
  logic [NRET-1:0]             rvfi_valid = '0;
  logic [64*NRET-1:0]          rvfi_order = '0;
  logic [XLEN*NRET-1:0]        rvfi_pc_rdata = '0;
  logic [XLEN*NRET-1:0]        rvfi_pc_wdata = '0;
  logic                        busy, done, fail;
  logic [1:0]                  fail_code;
  logic [$clog2(WINDOW)-1:0]   fail_slot;
  logic [$clog2(WINDOW+1)-1:0] checked_cnt;

  int      nCompared = 0;
  int      nMismatched = 0;
  int      cycCnt = 0;
  ev_t     stim[$];
  expect_t expQ[$];

  rvfi_pc_window_check #(
    .XLEN(XLEN), .NRET(NRET), .WINDOW(WINDOW), .ADDR_BITS(ADDR_BITS)
  ) dut (
    .clock(clock), .resetn(resetn), .arm(arm), .base_order(base_order),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .busy(busy), .done(done), .fail(fail), .fail_code(fail_code),
    .fail_slot(fail_slot), .checked_cnt(checked_cnt)
  );

  always #5 clock = ~clock;

  // Edge counter: after posedge N, cycCnt reads N at the following negedge.
  always @(posedge clock) cycCnt <= cycCnt + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input longint unsigned actual,
                             input longint unsigned expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference model. Each window entry remembers the first and second time it
  // was captured. A slot is judged one edge after both entries exist; a second
  // capture is a duplicate at its own edge. The earliest failure edge wins over
  // completion unless every slot completed strictly before it.
  function automatic expect_t predict(input longint unsigned base, input ev_t evs[$]);
    int              actT1[WINDOW], actT2[WINDOW], expT1[WINDOW], expT2[WINDOW];
    longint unsigned actV[WINDOW], expV[WINDOW];
    int              doneT[WINDOW], misT[WINDOW], dupT[WINDOW];
    int              f, d, t;
    expect_t         r;
    for (int k = 0; k < WINDOW; k++) begin
      actT1[k] = INF; actT2[k] = INF; expT1[k] = INF; expT2[k] = INF;
      actV[k] = 0; expV[k] = 0;
      doneT[k] = INF; misT[k] = INF;
    end
    if (base == 0) expT1[0] = 0;
    foreach (evs[i]) begin
      longint unsigned ao;
      longint unsigned eo;
      int              s;
      ao = evs[i].order - base;
      eo = ao + 1;
      if (ao < WINDOW) begin
        s = int'(ao);
        if (evs[i].cyc < actT1[s]) begin
          actT2[s] = actT1[s]; actT1[s] = evs[i].cyc; actV[s] = evs[i].rd;
        end else if (evs[i].cyc < actT2[s]) begin
          actT2[s] = evs[i].cyc;
        end
      end
      if (eo < WINDOW) begin
        s = int'(eo);
        if (evs[i].cyc < expT1[s]) begin
          expT2[s] = expT1[s]; expT1[s] = evs[i].cyc; expV[s] = evs[i].wd;
        end else if (evs[i].cyc < expT2[s]) begin
          expT2[s] = evs[i].cyc;
        end
      end
    end
    f = INF;
    d = 0;
    for (int k = 0; k < WINDOW; k++) begin
      dupT[k] = (actT2[k] < expT2[k]) ? actT2[k] : expT2[k];
      if (actT1[k] < INF && expT1[k] < INF) begin
        t = ((actT1[k] > expT1[k]) ? actT1[k] : expT1[k]) + 1;
        if ((k == 0 && base == 0) || (actV[k] % PCMOD == expV[k] % PCMOD)) doneT[k] = t;
        else misT[k] = t;
      end
      if (dupT[k] < f) f = dupT[k];
      if (misT[k] < f) f = misT[k];
      if (doneT[k] > d) d = doneT[k];
    end
    r.name = "";
    r.edgeAbs = 0;
    if (f < INF && f <= d) begin
      r.isDone = 1'b0;
      r.edgeRel = f;
      r.code = 2'b00;
      r.slot = -1;
      for (int k = 0; k < WINDOW; k++) begin
        if (dupT[k] == f) r.code[1] = 1'b1;
        if (misT[k] == f) r.code[0] = 1'b1;
        if ((dupT[k] == f || misT[k] == f) && r.slot < 0) r.slot = k;
      end
    end else begin
      r.isDone = 1'b1;
      r.edgeRel = d;
      r.code = 2'b00;
      r.slot = 0;
    end
    return r;
  endfunction

  task automatic addEv(input int c, input int ch, input longint unsigned o,
                       input logic [31:0] rd, input logic [31:0] wd);
    ev_t e;
    e.cyc = c; e.ch = ch; e.order = o; e.rd = rd; e.wd = wd;
    stim.push_back(e);
  endtask

  task automatic driveCycle(input int c);
    rvfi_valid = '0;
    foreach (stim[i]) begin
      if (stim[i].cyc == c) begin
        rvfi_valid[stim[i].ch]               = 1'b1;
        rvfi_order[64*stim[i].ch +: 64]      = stim[i].order;
        rvfi_pc_rdata[32*stim[i].ch +: 32]   = stim[i].rd;
        rvfi_pc_wdata[32*stim[i].ch +: 32]   = stim[i].wd;
      end
    end
  endtask

  // Arms the checker, plays the events in stim, and waits (bounded) for the
  // monitor to consume the predicted outcome.
  task automatic applyStimulus(input string name, input longint unsigned base);
    expect_t e;
    int      maxC;
    e = predict(base, stim);
    e.name = name;
    maxC = 0;
    foreach (stim[i]) if (stim[i].cyc > maxC) maxC = stim[i].cyc;
    @(negedge clock);
    arm = 1'b1;
    base_order = base;
    rvfi_valid = '0;
    e.edgeAbs = cycCnt + 1 + e.edgeRel;
    expQ.push_back(e);
    for (int c = 1; c <= maxC; c++) begin
      @(negedge clock);
      arm = 1'b0;
      driveCycle(c);
    end
    @(negedge clock);
    arm = 1'b0;
    rvfi_valid = '0;
    for (int i = 0; i < 20 && expQ.size() > 0; i++) @(negedge clock);
    if (expQ.size() != 0) begin
      checkOutput({name, "_timeout"}, expQ.size(), 0);
      expQ.delete();
    end
    stim.delete();
  endtask

  task automatic buildRandom(output longint unsigned base);
    logic [31:0] pcs[WINDOW+2];
    bit          used[8][NRET];
    int          c, ch, first, pick;
    ev_t         tmp;
    stim.delete();
    for (int i = 0; i < 8; i++) for (int j = 0; j < NRET; j++) used[i][j] = 1'b0;
    case ($urandom_range(0, 3))
      0:       base = 64'd0;
      1:       base = 64'($urandom_range(1, 100));
      2:       base = {$urandom, $urandom};
      default: base = 64'hFFFF_FFFF_FFFF_FFFE;
    endcase
    for (int i = 0; i < WINDOW + 2; i++) pcs[i] = $urandom & 32'hFFFF_FFFC;
    first = (base == 0) ? 1 : 0;
    for (int i = first; i <= WINDOW; i++) begin
      do begin
        c = $urandom_range(1, 6);
        ch = $urandom_range(0, NRET - 1);
      end while (used[c][ch]);
      used[c][ch] = 1'b1;
      addEv(c, ch, base - 1 + longint'(i), pcs[i], pcs[i+1]);
    end
    pick = $urandom_range(0, stim.size() - 1);
    tmp = stim[pick];
    case ($urandom_range(0, 5))
      0: tmp.rd = tmp.rd ^ (32'd1 << $urandom_range(2, 15));
      1: tmp.rd = tmp.rd ^ (32'd1 << $urandom_range(16, 31));
      2: tmp.wd = tmp.wd ^ (32'd1 << $urandom_range(2, 15));
      3: begin
        do begin
          c = $urandom_range(1, 7);
          ch = $urandom_range(0, NRET - 1);
        end while (used[c][ch]);
        used[c][ch] = 1'b1;
        tmp.cyc = c;
        tmp.ch = ch;
        stim.push_back(tmp);
        tmp = stim[pick];
      end
      default: ;
    endcase
    stim[pick] = tmp;
  endtask

  function automatic logic [31:0] pcOf(input longint unsigned o);
    return 32'h100 + 32'(4 * (o - 9));
  endfunction

  // Monitor: each rising done/fail is one window outcome.
  initial begin : monitor
    bit      prevOut;
    expect_t e;
    prevOut = 1'b0;
    forever begin
      @(negedge clock);
      if ((done || fail) && !prevOut) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_outcome", {done, fail}, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput({e.name, "_done"}, done, e.isDone);
          checkOutput({e.name, "_fail"}, fail, !e.isDone);
          checkOutput({e.name, "_busy"}, busy, 0);
          checkOutput({e.name, "_code"}, fail_code, e.code);
          checkOutput({e.name, "_edge"}, cycCnt, e.edgeAbs);
          if (e.isDone) checkOutput({e.name, "_checked"}, checked_cnt, WINDOW);
          else checkOutput({e.name, "_slot"}, fail_slot, e.slot);
        end
      end
      prevOut = done || fail;
    end
  end

  task automatic resetMidWindow();
    @(negedge clock);
    arm = 1'b1; base_order = 64'd50; rvfi_valid = '0;
    @(negedge clock);
    arm = 1'b0;
    rvfi_valid = 2'b01; rvfi_order[63:0] = 64'd49;
    rvfi_pc_rdata[31:0] = 32'h300; rvfi_pc_wdata[31:0] = 32'h304;
    @(negedge clock);
    rvfi_order[63:0] = 64'd50;
    rvfi_pc_rdata[31:0] = 32'h304; rvfi_pc_wdata[31:0] = 32'h308;
    @(negedge clock);
    rvfi_order[63:0] = 64'd51;
    rvfi_pc_rdata[31:0] = 32'h308; rvfi_pc_wdata[31:0] = 32'h30C;
    @(negedge clock);
    rvfi_valid = '0;
    checkOutput("pre_reset_busy", busy, 1);
    checkOutput("pre_reset_checked", checked_cnt, 1);
    #2 resetn = 1'b0;
    #1;
    checkOutput("mid_reset_busy", busy, 0);
    checkOutput("mid_reset_done", done, 0);
    checkOutput("mid_reset_fail", fail, 0);
    checkOutput("mid_reset_checked", checked_cnt, 0);
    checkOutput("mid_reset_code", fail_code, 0);
    @(negedge clock);
    resetn = 1'b1;
  endtask

  initial begin : stimulus
    longint unsigned base;
    #1 resetn = 1'b0;
    #2;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_fail", fail, 0);
    checkOutput("reset_code", fail_code, 0);
    checkOutput("reset_slot", fail_slot, 0);
    checkOutput("reset_checked", checked_cnt, 0);
    @(negedge clock);
    resetn = 1'b1;

    for (longint unsigned o = 9; o <= 13; o++) addEv(int'(o - 8), 0, o, pcOf(o), pcOf(o) + 4);
    applyStimulus("in_order_chain", 64'd10);

    for (longint unsigned o = 9; o <= 13; o++)
      addEv(int'(o - 8), 0, o, (o == 11) ? 32'h10C : pcOf(o), pcOf(o) + 4);
    applyStimulus("pc_mismatch", 64'd10);

    addEv(1, 0, 9, pcOf(9), pcOf(9) + 4);
    addEv(1, 1, 10, pcOf(10), pcOf(10) + 4);
    addEv(2, 1, 12, pcOf(12), pcOf(12) + 4);
    addEv(3, 0, 11, pcOf(11), pcOf(11) + 4);
    addEv(4, 0, 13, pcOf(13), pcOf(13) + 4);
    applyStimulus("out_of_order_dual", 64'd10);

    addEv(1, 0, 9, pcOf(9), pcOf(9) + 4);
    addEv(2, 0, 10, pcOf(10), pcOf(10) + 4);
    addEv(3, 0, 11, pcOf(11), pcOf(11) + 4);
    addEv(4, 0, 11, pcOf(11), pcOf(11) + 4);
    addEv(5, 0, 12, pcOf(12), pcOf(12) + 4);
    addEv(6, 0, 13, pcOf(13), pcOf(13) + 4);
    applyStimulus("duplicate_order", 64'd10);

    for (int o = 0; o <= 3; o++) addEv(o + 1, 0, longint'(o), 32'h200 + 32'(4 * o), 32'h204 + 32'(4 * o));
    applyStimulus("base_zero", 64'd0);

    for (longint unsigned o = 9; o <= 13; o++)
      addEv(int'(o - 8), 0, o, (o == 11) ? 32'h0000_0108 : pcOf(o),
            (o == 10) ? 32'hABCD_0108 : pcOf(o) + 4);
    applyStimulus("addr_bits_mask", 64'd10);

    resetMidWindow();
    for (longint unsigned o = 49; o <= 53; o++)
      addEv(int'(o - 48), 0, o, 32'h300 + 32'(4 * (o - 49)), 32'h304 + 32'(4 * (o - 49)));
    applyStimulus("rearm_after_reset", 64'd50);

    for (int n = 0; n < 40; n++) begin
      buildRandom(base);
      applyStimulus($sformatf("random%0d", n), base);
    end

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/rvfi_pc_window_check.md
Name: rvfi_pc_window_check

Overview:
- Multi-channel PC continuity checker, parametrised in XLEN, retire width and window depth.
- Verifies that for every instruction in a window of WINDOW consecutive rvfi_order values, its pc_rdata equals the pc_wdata of its predecessor.
- Pairs are matched regardless of retirement order or channel, so out-of-order and superscalar retirement are supported.
- Sits beside the RVFI monitor in formal/sim harnesses and reports status as outputs, so a bench or wrapper can assert on them.

Parameters:
- XLEN, 32, width of each PC field.
- NRET, 1, number of RVFI retire channels.
- WINDOW, 4, number of consecutive instructions checked; must be ≥2.
- ADDR_BITS, XLEN, number of low PC bits compared; bits above are ignored.

Ports:
- clock  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- arm  in  1  single-cycle start pulse; samples base_order.
- base_order  in  64  rvfi_order of the first checked instruction.
- rvfi_valid  in  NRET  per-channel retire valid.
- rvfi_order  in  64*NRET  per-channel order, channel i at [64*i +: 64].
- rvfi_pc_rdata  in  XLEN*NRET  per-channel PC of the retiring instruction.
- rvfi_pc_wdata  in  XLEN*NRET  per-channel next PC.
- busy  out  1  state is COLLECT.
- done  out  1  all WINDOW pairs checked with no failure.
- fail  out  1  sticky failure flag.
- fail_code  out  2  bit0 = PC mismatch, bit1 = duplicate order.
- fail_slot  out  max(1,$clog2(WINDOW))  lowest failing slot index.
- checked_cnt  out  $clog2(WINDOW+1)  number of slots checked so far.

Behaviour:
- Reset (resetn low, asynchronous): state IDLE; all outputs 0; all slot valid/checked bits clear; base register cleared.
- State machine states: IDLE, COLLECT, DONE, FAIL.
  - IDLE→COLLECT on arm.
  - COLLECT→DONE when checked_cnt reaches WINDOW.
  - COLLECT→FAIL on any failure.
  - DONE and FAIL hold until arm or reset.
  - arm in any state clears all slots, counters and flags, latches base_order, and enters COLLECT.
- Slot k (0..WINDOW-1) holds two entries:
  - exp[k] = pc_wdata of order base+k-1.
  - act[k] = pc_rdata of order base+k.
  - Each entry has its own valid bit.
- Window membership uses 64-bit modular arithmetic:
  - act slot d = order−base, captured when d < WINDOW.
  - exp slot e = order−base+1, captured when e < WINDOW.
  - A single retirement can fill act[d] and exp[d+1] on the same edge.
- base_order == 0: slot 0 has no predecessor. exp[0] is marked valid/equal at arm, so slot 0 completes when act[0] arrives.
- Capture happens only in COLLECT. Retirements on the arm cycle and in IDLE/DONE/FAIL are ignored.
- Duplicate detection:
  - A capture into an entry whose valid bit is already set is a duplicate, as are two channels hitting the same entry on one edge.
  - Sets fail_code[1]; fail is visible after the capturing edge.
- Check latency: a slot whose two entries become valid at edge T is evaluated at edge T+1.
  - Compare is on low ADDR_BITS only.
  - Equal: set checked bit; checked_cnt += number of slots completed that edge (several slots may complete per edge).
  - Unequal: set fail_code[0].
- Failure reporting:
  - Mismatch and duplicate on the same edge set both bits of fail_code.
  - fail_slot is the lowest slot index failing on that first failing edge.
  - fail, fail_code and fail_slot freeze once in FAIL.
- done and fail are mutually exclusive. A failure on the same edge the count would complete wins (FAIL).
- resetn asserted mid-COLLECT aborts immediately; a subsequent arm starts clean.

Test Plan:
- NRET=1, WINDOW=4, base=10: retire orders 9..13 with pc_rdata/pc_wdata chain 0x100→0x104→…→0x114 → checked_cnt steps to 4, done=1 one edge after order 13 captured, fail=0.
- Same setup, but order 11 has pc_rdata=0x10C while order 10 has pc_wdata=0x108 → fail=1, fail_code=01, fail_slot=1, done stays 0.
- NRET=2: order 12 on channel 1 one cycle before order 11 on channel 0, and orders 9/10 on both channels in the same cycle, correct chain → done=1, fail=0.
- Order 11 retired twice (second time in a later cycle) → fail_code=10, fail_slot=1 after the second capture edge.
- base=0, WINDOW=4: orders 0..3 correct chain → done=1, no predecessor required for slot 0.
- ADDR_BITS=16: order 10 pc_wdata=0xABCD0108, order 11 pc_rdata=0x00000108 → no fail. Separately, resetn pulsed low mid-COLLECT → busy/done/fail/checked_cnt read 0 immediately; re-arm and a full correct window → done=1.
